// File: rtl/note_stabilizer.sv
// rtl/note_stabilizer.sv - debounces raw note detections and presents a frame-aligned note/colour to the display stage
//
// Purpose:
//   Accepts a detected note only after MATCH_COUNT consecutive identical
//   valid detections, holds it until HOLD_CYCLES clk cycles pass with no
//   valid detection, then blanks to SILENT_NOTE. All display-facing outputs
//   change only on a frame_start cycle so the glyph never tears mid-frame.
//
// Ports:
//   clk          in   1   system clock
//   reset        in   1   synchronous active-low reset
//   det_note     in   6   raw detected note code, qualified by det_valid
//   det_valid    in   1   one-cycle strobe, det_note valid this cycle
//   frame_start  in   1   one-cycle strobe at start of vertical blanking
//   note         out  6   note code shown (SILENT_NOTE when idle), registered
//   color        out  24  glyph colour, registered
//   note_locked  out  1   high while a real note is shown, registered
//   note_changed out  1   one-cycle pulse when note changes value

module note_stabilizer #(
  parameter int unsigned MATCH_COUNT   = 4,
  parameter int unsigned HOLD_CYCLES   = 25000000,
  parameter int unsigned NUM_NOTES     = 48,
  parameter logic [5:0]  SILENT_NOTE   = 6'd63,
  parameter logic [23:0] COLOR_IDLE    = 24'h808080,
  parameter logic [23:0] COLOR_LOCKED  = 24'h00FF00,
  parameter logic [23:0] COLOR_PENDING = 24'hFFFF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  det_note,
  input  logic        det_valid,
  input  logic        frame_start,
  output logic [5:0]  note,
  output logic [23:0] color,
  output logic        note_locked,
  output logic        note_changed
);

  localparam int unsigned     TW        = $clog2(HOLD_CYCLES);
  localparam logic [TW-1:0]   TIMER_MAX = TW'(HOLD_CYCLES - 1);
  localparam logic [3:0]      CNT_MAX   = 4'(MATCH_COUNT);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [5:0]     shown_q, shown_d;
  logic [5:0]     cand_q, cand_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           upd_q, upd_d;
  logic [5:0]     note_q, note_d;
  logic [23:0]    color_q, color_d;
  logic           locked_q, locked_d;
  logic           changed_q, changed_d;

  logic           valid_code;
  logic           expired;

  assign valid_code = ({26'd0, det_note} < NUM_NOTES);
  assign expired    = (timer_q == TIMER_MAX);

  always_comb begin
    // Detection path: candidate tracking and hold timer.
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    if (det_valid) begin
      if (valid_code) begin
        if (det_note == cand_q) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;
        end else begin
          cand_d = det_note;
          cnt_d  = 4'd1;
        end
      end else begin
        // Silence breaks the run but does not restart the hold timer.
        cand_d = SILENT_NOTE;
        cnt_d  = 4'd0;
      end
    end

    if (det_valid && valid_code) begin
      timer_d = '0;
    end else if (expired) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    // Frame path: decisions use only registered (pre-detection) values,
    // so a detection landing on a frame_start cycle shows up next frame.
    state_d   = state_q;
    shown_d   = shown_q;
    note_d    = note_q;
    color_d   = color_q;
    locked_d  = locked_q;
    changed_d = 1'b0;
    if (frame_start) begin
      if (upd_q) begin
        state_d   = S_LOCKED;
        shown_d   = cand_q;
        changed_d = 1'b1;
      end else if (state_q == S_LOCKED && expired) begin
        state_d   = S_IDLE;
        changed_d = 1'b1;
      end

      note_d   = (state_d == S_LOCKED) ? shown_d : SILENT_NOTE;
      locked_d = (state_d == S_LOCKED);

      if (state_d == S_IDLE) begin
        color_d = COLOR_IDLE;
      end else if (cnt_q != 4'd0 && cand_q != shown_d) begin
        color_d = COLOR_PENDING;
      end else begin
        color_d = COLOR_LOCKED;
      end
    end

    // Update request reflects the state as it will be after this edge.
    upd_d = (cnt_d == CNT_MAX) && ((state_d == S_IDLE) || (cand_d != shown_d));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      shown_q   <= SILENT_NOTE;
      cand_q    <= SILENT_NOTE;
      cnt_q     <= 4'd0;
      timer_q   <= '0;
      upd_q     <= 1'b0;
      note_q    <= SILENT_NOTE;
      color_q   <= COLOR_IDLE;
      locked_q  <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shown_q   <= shown_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      upd_q     <= upd_d;
      note_q    <= note_d;
      color_q   <= color_d;
      locked_q  <= locked_d;
      changed_q <= changed_d;
    end
  end

  assign note         = note_q;
  assign color        = color_q;
  assign note_locked  = locked_q;
  assign note_changed = changed_q;

endmodule

// File: tb/tb_note_stabilizer.sv
// tb/tb_note_stabilizer.sv - self-checking bench for note_stabilizer

module tb_note_stabilizer;

  localparam int MC   = 3;
  localparam int HOLD = 100;
  localparam int NN   = 48;
  localparam int SIL  = 63;
  localparam int C_IDLE = 24'h808080;
  localparam int C_LOCK = 24'h00FF00;
  localparam int C_PEND = 24'hFFFF00;

  logic        clk;
  logic        reset;
  logic [5:0]  det_note;
  logic        det_valid;
  logic        frame_start;
  logic [5:0]  note;
  logic [23:0] color;
  logic        note_locked;
  logic        note_changed;

  note_stabilizer #(
    .MATCH_COUNT(MC),
    .HOLD_CYCLES(HOLD),
    .NUM_NOTES(NN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .det_note(det_note),
    .det_valid(det_valid),
    .frame_start(frame_start),
    .note(note),
    .color(color),
    .note_locked(note_locked),
    .note_changed(note_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: detection history plus edge counting, evaluated from the rules.
  int  hist[$];
  int  ecount     = 0;
  int  last_clear = 0;
  bit  showing    = 0;
  int  shown      = SIL;
  int  e_note     = SIL;
  int  e_color    = C_IDLE;
  int  e_locked   = 0;
  int  e_changed  = 0;
  int  m_cand;
  int  m_run;
  bit  m_expired;
  bit  s_r, s_fs, s_dv;
  int  s_dn;

  always begin
    @(posedge clk);
    s_r  = reset;
    s_fs = frame_start;
    s_dv = det_valid;
    s_dn = int'(det_note);
    ecount++;
    if (!s_r) begin
      hist.delete();
      showing    = 0;
      shown      = SIL;
      e_note     = SIL;
      e_color    = C_IDLE;
      e_locked   = 0;
      e_changed  = 0;
      last_clear = ecount;
    end else begin
      m_cand = -1;
      m_run  = 0;
      if (hist.size() > 0 && hist[$] >= 0) begin
        m_cand = hist[$];
        for (int i = hist.size() - 1; i >= 0 && hist[i] == m_cand; i--) m_run++;
        if (m_run > MC) m_run = MC;
      end
      m_expired = (ecount - 1 - last_clear) >= (HOLD - 1);
      e_changed = 0;
      if (s_fs) begin
        if (m_run == MC && (!showing || m_cand != shown)) begin
          showing   = 1;
          shown     = m_cand;
          e_changed = 1;
        end else if (showing && m_expired) begin
          showing   = 0;
          e_changed = 1;
        end
        e_note   = showing ? shown : SIL;
        e_locked = showing ? 1 : 0;
        if (!showing) e_color = C_IDLE;
        else if (m_run > 0 && m_cand != shown) e_color = C_PEND;
        else e_color = C_LOCK;
      end
      if (s_dv) begin
        if (s_dn < NN) begin
          hist.push_back(s_dn);
          last_clear = ecount;
        end else begin
          hist.push_back(-1);
        end
        if (hist.size() > 32) void'(hist.pop_front());
      end
    end
    #1;
    chk("model_note",    int'(note),         e_note);
    chk("model_color",   int'(color),        e_color);
    chk("model_locked",  int'(note_locked),  e_locked);
    chk("model_changed", int'(note_changed), e_changed);
  end

  task automatic step(input logic r, input logic fs, input logic dv, input logic [5:0] dn);
    reset       = r;
    frame_start = fs;
    det_valid   = dv;
    det_note    = dn;
    @(negedge clk);
  endtask

  task automatic det(input logic [5:0] dn);
    step(1'b1, 1'b0, 1'b1, dn);
  endtask

  task automatic frame();
    step(1'b1, 1'b1, 1'b0, 6'd0);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 6'd0);
  endtask

  initial begin
    // Reset
    step(1'b0, 1'b0, 1'b0, 6'd0);
    step(1'b0, 1'b0, 1'b0, 6'd0);
    chk("rst_note",    int'(note),         SIL);
    chk("rst_color",   int'(color),        C_IDLE);
    chk("rst_locked",  int'(note_locked),  0);
    chk("rst_changed", int'(note_changed), 0);
    idle();

    // Three matches of 12 then frame
    det(6'd12); det(6'd12); det(6'd12);
    frame();
    chk("t1_note",    int'(note),         12);
    chk("t1_locked",  int'(note_locked),  1);
    chk("t1_color",   int'(color),        C_LOCK);
    chk("t1_changed", int'(note_changed), 1);
    idle();
    chk("t1_pulse_end", int'(note_changed), 0);

    // Interrupted challenger returns to shown note
    det(6'd20); det(6'd20); det(6'd12);
    frame();
    chk("t2_note",    int'(note),         12);
    chk("t2_color",   int'(color),        C_LOCK);
    chk("t2_changed", int'(note_changed), 0);

    // Pending challenger, then takeover
    det(6'd20); det(6'd20);
    frame();
    chk("t3_note_hold", int'(note),  12);
    chk("t3_pending",   int'(color), C_PEND);
    det(6'd20);
    frame();
    chk("t3_note_new",  int'(note),         20);
    chk("t3_changed",   int'(note_changed), 1);
    chk("t3_color",     int'(color),        C_LOCK);

    // Hold timeout: relock 12, last valid detection at edge c
    det(6'd12); det(6'd12); det(6'd12);
    frame();                                   // edge c+1
    chk("t4_relock", int'(note), 12);
    for (int k = 2; k <= 98; k++) begin        // edges c+2 .. c+98
      if (k % 10 == 0) det(6'd50);
      else idle();
    end
    frame();                                   // edge c+99, timer 98
    chk("t4_not_expired", int'(note), 12);
    frame();                                   // edge c+100, timer 99
    chk("t4_note",    int'(note),         SIL);
    chk("t4_locked",  int'(note_locked),  0);
    chk("t4_color",   int'(color),        C_IDLE);
    chk("t4_changed", int'(note_changed), 1);

    // Third match coincides with frame_start
    det(6'd7); det(6'd7);
    step(1'b1, 1'b1, 1'b1, 6'd7);
    chk("t5_same_frame", int'(note),         SIL);
    chk("t5_no_pulse",   int'(note_changed), 0);
    frame();
    chk("t5_next_frame", int'(note),         7);
    chk("t5_changed",    int'(note_changed), 1);

    // Reset discards a pending update
    det(6'd5); det(6'd5); det(6'd5);
    step(1'b0, 1'b0, 1'b0, 6'd0);
    frame();
    chk("t6_note",    int'(note),         SIL);
    chk("t6_locked",  int'(note_locked),  0);
    chk("t6_changed", int'(note_changed), 0);

    // Invalid code breaks the run
    det(6'd9); det(6'd9); det(6'd50); det(6'd9);
    frame();
    chk("t7_broken", int'(note), SIL);
    det(6'd9); det(6'd9);
    frame();
    chk("t7_note", int'(note), 9);

    idle(); idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
